// File: rtl/light_mode_scheduler_if.sv
// Light mode scheduler bus: groups the user controls and the display-side outputs.
//   btn_next        raw push-button, high = pressed (asynchronous, bouncing)
//   dir             step direction, 0 = increment, 1 = decrement
//   auto_en         1 = automatic mode cycling
//   pause           1 = freeze the auto dwell countdown
//   dwell_sel[1:0]  dwell-time select used at the next counter load
//   light_mode[1:0] pattern select for the running-light display
//   mode_strobe     one-cycle pulse in the cycle after each light_mode change
//   auto_active     high while in AUTO or PAUSED
//   dwell_remaining cycles left before the next auto advance, 0 in MANUAL
// master drives the controls, slave is the scheduler.
interface light_mode_scheduler_if;
    logic       btn_next;
    logic       dir;
    logic       auto_en;
    logic       pause;
    logic [1:0] dwell_sel;
    logic [1:0] light_mode;
    logic       mode_strobe;
    logic       auto_active;
    logic [8:0] dwell_remaining;

    modport master (
        output btn_next, dir, auto_en, pause, dwell_sel,
        input  light_mode, mode_strobe, auto_active, dwell_remaining
    );

    modport slave (
        input  btn_next, dir, auto_en, pause, dwell_sel,
        output light_mode, mode_strobe, auto_active, dwell_remaining
    );
endinterface

// File: rtl/light_mode_scheduler.sv
// Light mode scheduler: selects the running-light pattern either by debounced
// button presses or by timed automatic cycling with a selectable dwell time.
//   Clk  system clock, all state updates on its rising edge
//   Rst  asynchronous, active-high reset
//   bus  light_mode_scheduler_if.slave (controls in, display outputs out)
module light_mode_scheduler #(
    parameter int unsigned DEBOUNCE_CYCLES = 2,
    parameter int unsigned DWELL_T0        = 50,
    parameter int unsigned DWELL_T1        = 100,
    parameter int unsigned DWELL_T2        = 200,
    parameter int unsigned DWELL_T3        = 300
) (
    input logic                    Clk,
    input logic                    Rst,
    light_mode_scheduler_if.slave  bus
);

    localparam logic [1:0] ST_MANUAL = 2'd0;
    localparam logic [1:0] ST_AUTO   = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;

    localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [8:0] DWELL_0  = 9'(DWELL_T0);
    localparam logic [8:0] DWELL_1  = 9'(DWELL_T1);
    localparam logic [8:0] DWELL_2  = 9'(DWELL_T2);
    localparam logic [8:0] DWELL_3  = 9'(DWELL_T3);

    logic       sync_1, sync_2;
    logic       deb_level, deb_level_d;
    logic [3:0] stab_cnt, stab_cnt_d;
    logic [1:0] state, state_d;
    logic [8:0] dwell_cnt, dwell_cnt_d;
    logic [1:0] mode, mode_d;
    logic       strobe, active;

    logic       deb_accept;
    logic       press;
    logic       running;
    logic       expire;
    logic [8:0] reload_val;
    logic [1:0] stepped;

    // Debounce and press detection. The press is taken on the same edge the
    // debounced level flips, so light_mode moves together with it.
    always_comb begin
        deb_accept  = (sync_2 != deb_level) && (stab_cnt == DEB_LAST);
        press       = deb_accept && sync_2;
        deb_level_d = deb_accept ? sync_2 : deb_level;
        if (sync_2 == deb_level || deb_accept) begin
            stab_cnt_d = 4'd0;
        end else begin
            stab_cnt_d = stab_cnt + 4'd1;
        end
    end

    always_comb begin
        case (bus.dwell_sel)
            2'd0:    reload_val = DWELL_0;
            2'd1:    reload_val = DWELL_1;
            2'd2:    reload_val = DWELL_2;
            default: reload_val = DWELL_3;
        endcase
    end

    // Countdown runs only while in AUTO and the inputs still ask for AUTO, so
    // the edge entering or leaving PAUSED holds the count.
    always_comb begin
        stepped = bus.dir ? (mode - 2'd1) : (mode + 2'd1);
        running = (state == ST_AUTO) && bus.auto_en && !bus.pause;
        expire  = running && (dwell_cnt == 9'd1);

        state_d     = state;
        dwell_cnt_d = dwell_cnt;
        if (!bus.auto_en) begin
            state_d     = ST_MANUAL;
            dwell_cnt_d = 9'd0;
        end else begin
            state_d = bus.pause ? ST_PAUSED : ST_AUTO;
            if (state == ST_MANUAL || press || expire) begin
                dwell_cnt_d = reload_val;
            end else if (running) begin
                dwell_cnt_d = dwell_cnt - 9'd1;
            end
        end

        // Press and expiry on the same edge still give a single step.
        mode_d = (press || expire) ? stepped : mode;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            deb_level <= 1'b0;
            stab_cnt  <= 4'd0;
            state     <= ST_MANUAL;
            dwell_cnt <= 9'd0;
            mode      <= 2'd0;
            strobe    <= 1'b0;
            active    <= 1'b0;
        end else begin
            sync_1    <= bus.btn_next;
            sync_2    <= sync_1;
            deb_level <= deb_level_d;
            stab_cnt  <= stab_cnt_d;
            state     <= state_d;
            dwell_cnt <= dwell_cnt_d;
            mode      <= mode_d;
            strobe    <= (mode_d != mode);
            active    <= (state_d != ST_MANUAL);
        end
    end

    assign bus.light_mode      = mode;
    assign bus.mode_strobe     = strobe;
    assign bus.auto_active     = active;
    assign bus.dwell_remaining = dwell_cnt;

endmodule

// File: tb/tb_light_mode_scheduler.sv
// Directed bench for light_mode_scheduler with default parameters.
module tb_light_mode_scheduler;

    logic Clk;
    logic Rst;
    int   total;
    int   bad;

    light_mode_scheduler_if bus ();

    light_mode_scheduler dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press_release();
        bus.btn_next = 1'b1;
        repeat (4) tick();
        bus.btn_next = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        logic [8:0] exp_cnt;
        logic [1:0] exp_mode;
        logic       exp_strobe;

        total         = 0;
        bad           = 0;
        Rst           = 1'b1;
        bus.btn_next  = 1'b0;
        bus.dir       = 1'b0;
        bus.auto_en   = 1'b0;
        bus.pause     = 1'b0;
        bus.dwell_sel = 2'd0;

        // Reset values
        repeat (3) tick();
        check("rst_mode", 32'(bus.light_mode), 0);
        check("rst_strobe", 32'(bus.mode_strobe), 0);
        check("rst_active", 32'(bus.auto_active), 0);
        check("rst_dwell", 32'(bus.dwell_remaining), 0);
        Rst = 1'b0;
        repeat (5) tick();

        // Scenario 1: held key, latency k+1+2, single advance
        bus.btn_next = 1'b1;
        tick();
        check("s1_mode_k", 32'(bus.light_mode), 0);
        tick();
        tick();
        check("s1_mode_k2", 32'(bus.light_mode), 0);
        check("s1_strobe_k2", 32'(bus.mode_strobe), 0);
        tick();
        check("s1_mode_k3", 32'(bus.light_mode), 1);
        check("s1_strobe_k3", 32'(bus.mode_strobe), 1);
        tick();
        check("s1_strobe_k4", 32'(bus.mode_strobe), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("s1_hold_mode", 32'(bus.light_mode), 1);
            check("s1_hold_strobe", 32'(bus.mode_strobe), 0);
        end
        bus.btn_next = 1'b0;
        repeat (6) tick();
        check("s1_release_mode", 32'(bus.light_mode), 1);

        // Reset pulse back to mode 0
        Rst = 1'b1;
        #1;
        check("rst2_mode", 32'(bus.light_mode), 0);
        tick();
        Rst = 1'b0;
        repeat (3) tick();

        // Scenario 2: one-cycle glitches never accepted
        for (int i = 0; i < 10; i++) begin
            bus.btn_next = 1'b1;
            tick();
            check("s2_strobe_hi", 32'(bus.mode_strobe), 0);
            bus.btn_next = 1'b0;
            tick();
            check("s2_strobe_lo", 32'(bus.mode_strobe), 0);
        end
        repeat (6) tick();
        check("s2_mode", 32'(bus.light_mode), 0);

        // Manual wrap in both directions
        bus.dir = 1'b1;
        press_release();
        check("wrap_dec", 32'(bus.light_mode), 3);
        bus.dir = 1'b0;
        press_release();
        check("wrap_inc", 32'(bus.light_mode), 0);
        check("manual_dwell", 32'(bus.dwell_remaining), 0);

        // Scenario 3: auto cycling, dir=1, 50-cycle dwell
        bus.dir       = 1'b1;
        bus.dwell_sel = 2'd0;
        bus.auto_en   = 1'b1;
        tick();
        check("s3_load", 32'(bus.dwell_remaining), 50);
        check("s3_active", 32'(bus.auto_active), 1);
        exp_cnt  = 9'd50;
        exp_mode = 2'd0;
        for (int i = 0; i < 200; i++) begin
            tick();
            exp_strobe = (exp_cnt == 9'd1);
            if (exp_cnt == 9'd1) begin
                exp_mode = exp_mode - 2'd1;
                exp_cnt  = 9'd50;
            end else begin
                exp_cnt = exp_cnt - 9'd1;
            end
            check("s3_mode", 32'(bus.light_mode), 32'(exp_mode));
            check("s3_dwell", 32'(bus.dwell_remaining), 32'(exp_cnt));
            check("s3_strobe", 32'(bus.mode_strobe), 32'(exp_strobe));
        end

        // Scenario 4: pause at 20 for 100 cycles
        repeat (30) tick();
        check("s4_pre", 32'(bus.dwell_remaining), 20);
        bus.pause = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("s4_hold_dwell", 32'(bus.dwell_remaining), 20);
            check("s4_hold_mode", 32'(bus.light_mode), 0);
            check("s4_hold_active", 32'(bus.auto_active), 1);
        end
        bus.pause = 1'b0;
        tick();
        check("s4_resume", 32'(bus.dwell_remaining), 20);
        repeat (19) tick();
        check("s4_last_dwell", 32'(bus.dwell_remaining), 1);
        check("s4_last_mode", 32'(bus.light_mode), 0);
        tick();
        check("s4_adv_mode", 32'(bus.light_mode), 3);
        check("s4_adv_dwell", 32'(bus.dwell_remaining), 50);

        // Scenario 5: dwell_sel change leaves running count; press on expiry edge
        bus.dwell_sel = 2'd1;
        tick();
        check("s5_sel_run", 32'(bus.dwell_remaining), 49);
        repeat (45) tick();
        check("s5_pre", 32'(bus.dwell_remaining), 4);
        bus.btn_next = 1'b1;
        repeat (3) tick();
        check("s5_at1_dwell", 32'(bus.dwell_remaining), 1);
        check("s5_at1_mode", 32'(bus.light_mode), 3);
        tick();
        check("s5_mode", 32'(bus.light_mode), 2);
        check("s5_dwell", 32'(bus.dwell_remaining), 100);
        check("s5_strobe", 32'(bus.mode_strobe), 1);
        tick();
        check("s5_mode_after", 32'(bus.light_mode), 2);
        check("s5_dwell_after", 32'(bus.dwell_remaining), 99);
        check("s5_strobe_after", 32'(bus.mode_strobe), 0);
        bus.btn_next = 1'b0;
        repeat (6) tick();
        check("s5_release_dwell", 32'(bus.dwell_remaining), 93);
        check("s5_release_mode", 32'(bus.light_mode), 2);

        // Mid-dwell press reloads with the new selection
        bus.dwell_sel = 2'd2;
        bus.btn_next  = 1'b1;
        repeat (4) tick();
        check("press_mode", 32'(bus.light_mode), 1);
        check("press_dwell", 32'(bus.dwell_remaining), 200);
        bus.btn_next = 1'b0;
        repeat (6) tick();
        check("press_rel_dwell", 32'(bus.dwell_remaining), 194);

        // Scenario 6: reset at mode 2 in AUTO with key held
        bus.dir      = 1'b0;
        bus.btn_next = 1'b1;
        repeat (4) tick();
        check("s6_mode2", 32'(bus.light_mode), 2);
        repeat (3) tick();
        check("s6_held_mode", 32'(bus.light_mode), 2);
        check("s6_held_dwell", 32'(bus.dwell_remaining), 197);
        Rst         = 1'b1;
        bus.auto_en = 1'b0;
        #1;
        check("s6_rst_mode", 32'(bus.light_mode), 0);
        check("s6_rst_strobe", 32'(bus.mode_strobe), 0);
        check("s6_rst_active", 32'(bus.auto_active), 0);
        check("s6_rst_dwell", 32'(bus.dwell_remaining), 0);
        tick();
        tick();
        check("s6_rst_hold_mode", 32'(bus.light_mode), 0);
        Rst = 1'b0;
        repeat (3) tick();
        check("s6_redeb_k2", 32'(bus.light_mode), 0);
        tick();
        check("s6_redeb_k3", 32'(bus.light_mode), 1);
        check("s6_redeb_strobe", 32'(bus.mode_strobe), 1);

        // MANUAL -> PAUSED loads, then auto_en=0 clears and holds mode
        bus.auto_en = 1'b1;
        bus.pause   = 1'b1;
        tick();
        check("mp_active", 32'(bus.auto_active), 1);
        check("mp_dwell", 32'(bus.dwell_remaining), 200);
        tick();
        check("mp_hold", 32'(bus.dwell_remaining), 200);
        bus.auto_en = 1'b0;
        tick();
        check("pm_dwell", 32'(bus.dwell_remaining), 0);
        check("pm_active", 32'(bus.auto_active), 0);
        check("pm_mode", 32'(bus.light_mode), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/light_mode_scheduler.md
LIGHT_MODE_SCHEDULER -- requirements
Module: light_mode_scheduler

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 2, SHALL set the consecutive stable cycles required to accept a btn_next level change (legal 1..15).
REQ-002 Parameters DWELL_T0/T1/T2/T3, defaults 50/100/200/300, SHALL set the auto-mode dwell in Clk cycles for dwell_sel 0/1/2/3 (legal 1..511).
REQ-003 Clk  input  1  system clock, fixed 10 Hz; all state SHALL update on its rising edge.
REQ-004 Rst  input  1  reset, asynchronous, active-high.
REQ-005 btn_next  input  1  raw, asynchronous, bouncing key; high = pressed.
REQ-006 dir  input  1  step direction; 0 = increment mode, 1 = decrement mode.
REQ-007 auto_en  input  1  switch; 1 = automatic mode cycling.
REQ-008 pause  input  1  switch; 1 = freeze the auto dwell countdown.
REQ-009 dwell_sel  input  2  dwell-time select for the next counter load.
REQ-010 light_mode  output  2  registered pattern select driving the running-light display block.
REQ-011 mode_strobe  output  1  registered one-cycle pulse, high in the cycle after every light_mode change.
REQ-012 auto_active  output  1  registered; high in the AUTO or PAUSED state.
REQ-013 dwell_remaining  output  9  registered cycles left before the next auto advance; 0 in MANUAL.

Function
REQ-014 btn_next SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Debounce: the debounced level SHALL take the synchronized value only after that value differs from it for DEBOUNCE_CYCLES consecutive edges; any return to equality SHALL clear the stability count.
REQ-016 Press event: a debounced 0->1 transition SHALL produce exactly one advance; a held key SHALL NOT repeat; the release SHALL produce no advance.
REQ-017 Press latency: if edge k is the first edge at which btn_next=1 is sampled, and the key is held stable, light_mode SHALL update at edge k+1+DEBOUNCE_CYCLES.
REQ-018 Advance: dir=0 SHALL step light_mode 0->1->2->3->0. dir=1 SHALL step 3->2->1->0->3. Wrap-around is modulo 4.
REQ-019 State machine SHALL have the states MANUAL, AUTO and PAUSED.
REQ-020 MANUAL->AUTO SHALL occur when auto_en=1 and pause=0; the dwell counter SHALL load DWELL_T[dwell_sel] on that edge.
REQ-021 MANUAL->PAUSED SHALL occur when auto_en=1 and pause=1; the dwell counter SHALL load on that edge.
REQ-022 AUTO<->PAUSED SHALL follow pause; the counter value SHALL be held across the transition.
REQ-023 Any state->MANUAL SHALL occur when auto_en=0; the counter SHALL clear to 0 and light_mode SHALL hold its current value.
REQ-024 AUTO: the counter SHALL decrement by 1 per edge; on an edge where it equals 1, light_mode SHALL advance and the counter SHALL reload, so each mode lasts exactly DWELL_T[dwell_sel] cycles.
REQ-025 PAUSED: the counter SHALL hold; timed advances SHALL be suppressed.
REQ-026 A change of dwell_sel SHALL affect only the next reload, never the running count.
REQ-027 Press events SHALL advance light_mode in all states; in AUTO and PAUSED a press SHALL also reload the counter.
REQ-028 Simultaneous press and dwell expiry SHALL produce a single advance plus a reload, never a double step.
REQ-029 mode_strobe SHALL be high for exactly one cycle after each light_mode change and never otherwise.
REQ-030 dwell_remaining SHALL equal the internal counter, registered with no additional lag.

Reset
REQ-031 While Rst=1, all outputs SHALL hold: light_mode=00, mode_strobe=0, auto_active=0, dwell_remaining=0.
REQ-032 While Rst=1, the state SHALL be MANUAL and the synchronizer, debounced level and stability count SHALL be 0.
REQ-033 Rst asserted mid-dwell or mid-debounce SHALL abort the operation immediately; after release, operation SHALL restart from the REQ-031/REQ-032 values, and a still-held key SHALL be debounced afresh.

Verification
REQ-034 Scenario 1: defaults, MANUAL, dir=0; btn_next held high from edge 10 -> light_mode 00->01 at edge 13, mode_strobe high only during cycle 13-14, no further change while held.
REQ-035 Scenario 2: btn_next glitches 1 cycle high, 1 cycle low, repeated 10 times -> light_mode stays 00 and mode_strobe stays 0.
REQ-036 Scenario 3: auto_en=1, dwell_sel=0, dir=1 -> sequence 00,11,10,01,00, each value held exactly 50 cycles; dwell_remaining counts 50..1.
REQ-037 Scenario 4: in AUTO, pause=1 at dwell_remaining=20 for 100 cycles, then pause=0 -> light_mode unchanged during pause; advance occurs 20 cycles after release.
REQ-038 Scenario 5: press accepted on the same edge the counter reaches 1 -> light_mode moves one step only, dwell_remaining reloads to DWELL_T[dwell_sel].
REQ-039 Scenario 6: Rst pulsed at light_mode=10 in AUTO -> outputs 00/0/0/0 immediately; a held key is ignored until the full debounce interval has elapsed again.
